// File: rtl/branch_predictor_bht.sv
// Fetch-side direction/target predictor: 2-bit bimodal BHT plus a direct-mapped tagged BTB,
// trained from execute-stage resolution, with flush/redirect and saturating perf counters.
module branch_predictor_bht #(
    parameter int size        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_BITS    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] if_pc_i,
    input  logic            if_is_branch_i,
    input  logic            if_is_jump_i,
    output logic            Predicted_MPC_o,
    output logic [size-1:0] Predicted_PC_o,
    input  logic            ex_valid_i,
    input  logic [size-1:0] ex_pc_i,
    input  logic            ex_is_branch_i,
    input  logic            Real_MPC_i,
    input  logic [size-1:0] ex_target_i,
    input  logic            isValid_i,
    input  logic [size-1:0] Correct_PC_i,
    output logic            flush_o,
    output logic [size-1:0] redirect_pc_o,
    output logic [31:0]     branch_count_o,
    output logic [31:0]     mispredict_count_o
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_LO = BTB_IW + 2;

    logic [1:0]          bht        [BHT_ENTRIES];
    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
    logic [size-1:0]     btb_target [BTB_ENTRIES];

    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    logic [BHT_IW-1:0]   if_bht_idx, ex_bht_idx;
    logic [BTB_IW-1:0]   if_btb_idx, ex_btb_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                hit;
    logic                bht_we, btb_we;
    logic [1:0]          bht_cur, bht_next;
    logic                unused;

    assign if_bht_idx = if_pc_i[BHT_IW+1:2];
    assign ex_bht_idx = ex_pc_i[BHT_IW+1:2];
    assign if_btb_idx = if_pc_i[BTB_IW+1:2];
    assign ex_btb_idx = ex_pc_i[BTB_IW+1:2];
    assign if_tag     = if_pc_i[TAG_LO+TAG_BITS-1:TAG_LO];
    assign ex_tag     = ex_pc_i[TAG_LO+TAG_BITS-1:TAG_LO];
    assign unused     = ^{if_pc_i, ex_pc_i};

    // Lookup reads the stored arrays directly, so a same-cycle write is not bypassed.
    assign hit = reset && btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);

    always_comb begin
        Predicted_MPC_o = (if_is_branch_i && hit && bht[if_bht_idx][1]) || (if_is_jump_i && hit);
        Predicted_PC_o  = Predicted_MPC_o ? btb_target[if_btb_idx] : if_pc_i + size'(4);
    end

    assign flush_o       = reset && ex_valid_i && !isValid_i;
    assign redirect_pc_o = flush_o ? Correct_PC_i : '0;

    assign bht_we = ex_valid_i && ex_is_branch_i;
    assign btb_we = ex_valid_i && (!ex_is_branch_i || Real_MPC_i);

    always_comb begin
        bht_cur  = bht[ex_bht_idx];
        bht_next = bht_cur;
        if (Real_MPC_i && bht_cur != 2'b11) begin
            bht_next = bht_cur + 2'b01;
        end else if (!Real_MPC_i && bht_cur != 2'b00) begin
            bht_next = bht_cur - 2'b01;
        end
    end

    // NOTE: only the BHT counters and BTB valid bits need a reset value; tag and
    // target payloads stay reset-free since an invalid entry never exposes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
        end else begin
            if (bht_we) bht[ex_bht_idx] <= bht_next;
            if (btb_we) btb_valid[ex_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && btb_we) begin
            btb_tag[ex_btb_idx]    <= ex_tag;
            btb_target[ex_btb_idx] <= ex_target_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (ex_valid_i && branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
            if (flush_o && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign branch_count_o     = branch_cnt;
    assign mispredict_count_o = mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed-vector bench for branch_predictor_bht with hand-computed expectations
// (default parameters: BHT idx = pc[7:2], BTB idx = pc[5:2], tag = pc[13:6]).
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc_i;
    logic        if_is_branch_i, if_is_jump_i;
    logic        Predicted_MPC_o;
    logic [31:0] Predicted_PC_o;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_is_branch_i, Real_MPC_i;
    logic [31:0] ex_target_i;
    logic        isValid_i;
    logic [31:0] Correct_PC_i;
    logic        flush_o;
    logic [31:0] redirect_pc_o, branch_count_o, mispredict_count_o;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor_bht dut (
        .clk(clk), .reset(reset),
        .if_pc_i(if_pc_i), .if_is_branch_i(if_is_branch_i), .if_is_jump_i(if_is_jump_i),
        .Predicted_MPC_o(Predicted_MPC_o), .Predicted_PC_o(Predicted_PC_o),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_is_branch_i(ex_is_branch_i),
        .Real_MPC_i(Real_MPC_i), .ex_target_i(ex_target_i), .isValid_i(isValid_i),
        .Correct_PC_i(Correct_PC_i), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic br, input logic jmp);
        if_pc_i = pc; if_is_branch_i = br; if_is_jump_i = jmp;
        #1;
    endtask

    task automatic expect_pred(input string tag, input logic mpc, input logic [31:0] pc);
        check({tag, "_mpc"}, {31'd0, Predicted_MPC_o}, {31'd0, mpc});
        check({tag, "_pc"}, Predicted_PC_o, pc);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic taken,
                           input logic [31:0] tgt, input logic ok, input logic [31:0] corr);
        ex_valid_i = 1'b1; ex_pc_i = pc; ex_is_branch_i = br; Real_MPC_i = taken;
        ex_target_i = tgt; isValid_i = ok; Correct_PC_i = corr;
        #1;
    endtask

    task automatic idle_ex();
        ex_valid_i = 1'b0; isValid_i = 1'b1; Real_MPC_i = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        if_pc_i = 32'h100; if_is_branch_i = 1'b1; if_is_jump_i = 1'b0;
        ex_valid_i = 1'b0; ex_pc_i = '0; ex_is_branch_i = 1'b0; Real_MPC_i = 1'b0;
        ex_target_i = '0; isValid_i = 1'b1; Correct_PC_i = '0;
        repeat (2) tick();

        // 1: reset state
        expect_pred("rst_lookup", 1'b0, 32'h104);
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h80);
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_redirect", redirect_pc_o, 32'd0);
        tick();
        check("rst_bcnt", branch_count_o, 32'd0);
        check("rst_mcnt", mispredict_count_o, 32'd0);
        idle_ex();
        reset = 1'b1;
        tick();

        // 2: train 0x100 taken twice; first mispredicted
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 32'h80);
        lookup(32'h100, 1'b1, 1'b0);
        check("t2_flush", {31'd0, flush_o}, 32'd1);
        check("t2_redirect", redirect_pc_o, 32'h80);
        expect_pred("t2_prewrite", 1'b0, 32'h104);
        tick();
        expect_pred("t2_ctr2", 1'b1, 32'h80);
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
        check("t2_noflush", {31'd0, flush_o}, 32'd0);
        check("t2_noredirect", redirect_pc_o, 32'd0);
        tick();
        expect_pred("t2_ctr3", 1'b1, 32'h80);
        check("t2_bcnt", branch_count_o, 32'd2);
        check("t2_mcnt", mispredict_count_o, 32'd1);
        lookup(32'h100, 1'b0, 1'b0);
        expect_pred("t2_nonctl", 1'b0, 32'h104);
        lookup(32'h100, 1'b1, 1'b0);

        // 3: not-taken walk 3->2->1->0, 0 holds, then back up
        resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104);
        tick();
        expect_pred("t3_ctr2", 1'b1, 32'h80);
        tick();
        expect_pred("t3_ctr1", 1'b0, 32'h104);
        tick();
        expect_pred("t3_ctr0", 1'b0, 32'h104);
        tick();
        expect_pred("t3_hold0", 1'b0, 32'h104);
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
        tick();
        expect_pred("t3_up1", 1'b0, 32'h104);
        tick();
        expect_pred("t3_up2", 1'b1, 32'h80);
        check("t3_bcnt", branch_count_o, 32'd8);

        // ex_valid=0: nothing moves even with mispredict-looking inputs
        resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104);
        ex_valid_i = 1'b0;
        #1;
        check("nv_flush", {31'd0, flush_o}, 32'd0);
        tick();
        expect_pred("nv_bht", 1'b1, 32'h80);
        check("nv_bcnt", branch_count_o, 32'd8);
        check("nv_mcnt", mispredict_count_o, 32'd1);

        // 4: JALR at 0x200 -> 0x3C0, mispredicted
        resolve(32'h200, 1'b0, 1'b1, 32'h3C0, 1'b0, 32'h3C0);
        check("t4_flush", {31'd0, flush_o}, 32'd1);
        check("t4_redirect", redirect_pc_o, 32'h3C0);
        tick();
        idle_ex();
        lookup(32'h200, 1'b0, 1'b1);
        expect_pred("t4_jump", 1'b1, 32'h3C0);
        lookup(32'h200, 1'b1, 1'b0);
        expect_pred("t4_bht_kept", 1'b1, 32'h3C0);
        lookup(32'h100, 1'b1, 1'b0);
        expect_pred("t4_evicted", 1'b0, 32'h104);
        check("t4_bcnt", branch_count_o, 32'd9);
        check("t4_mcnt", mispredict_count_o, 32'd2);

        // 5: aliasing. 0x140 shares BTB entry 0 with tag 5 -> miss.
        lookup(32'h140, 1'b1, 1'b0);
        expect_pred("t5_tagmiss", 1'b0, 32'h144);
        resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
        lookup(32'h100, 1'b1, 1'b0);
        expect_pred("t5_sameedge_old", 1'b0, 32'h104);
        tick();
        idle_ex();
        expect_pred("t5_new", 1'b1, 32'h80);
        // 0x4100 = 0x100 + 16*4*256 wraps past the tag field: same index and same tag
        lookup(32'h4100, 1'b1, 1'b0);
        expect_pred("t5_fullalias", 1'b1, 32'h80);
        check("t5_bcnt", branch_count_o, 32'd10);

        // 6: reset mid-train clears asynchronously
        resolve(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h104);
        lookup(32'h100, 1'b1, 1'b0);
        check("t6_flush_pre", {31'd0, flush_o}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_flush_async", {31'd0, flush_o}, 32'd0);
        check("t6_redirect_async", redirect_pc_o, 32'd0);
        check("t6_bcnt_async", branch_count_o, 32'd0);
        check("t6_mcnt_async", mispredict_count_o, 32'd0);
        expect_pred("t6_pred_async", 1'b0, 32'h104);
        tick();
        check("t6_bcnt_held", branch_count_o, 32'd0);
        idle_ex();
        reset = 1'b1;
        tick();
        expect_pred("t6_tables_clear", 1'b0, 32'h104);

        // saturation of the perf counters
        force dut.branch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        resolve(32'h300, 1'b0, 1'b1, 32'h500, 1'b1, 32'h500);
        tick();
        check("sat_bcnt", branch_count_o, 32'hFFFF_FFFF);
        check("sat_mcnt0", mispredict_count_o, 32'd0);
        isValid_i = 1'b0;
        tick();
        check("sat_bcnt2", branch_count_o, 32'hFFFF_FFFF);
        check("sat_mcnt1", mispredict_count_o, 32'd1);
        idle_ex();
        lookup(32'h300, 1'b0, 1'b1);
        expect_pred("sat_jump", 1'b1, 32'h500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
